// File: rtl/pipe_pkg.sv
// Shared pipeline types: shadow-stage entry, forward-select codes, operand-unused marker.
package pipe_pkg;

    // tuse value meaning the operand is not read at all
    localparam logic [1:0] TUSE_NONE = 2'd3;

    // D-stage forward source
    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2,
        FWD_W  = 2'd3
    } fwd_sel_t;

    // Pending register write tracked alongside the real E/M/W stages
    typedef struct packed {
        logic [4:0] dst;
        logic [1:0] tnew;
        logic       md;
    } shadow_t;

    // Advance an entry by one stage: remaining latency drops by one, floored at 0
    function automatic shadow_t age(input shadow_t s);
        shadow_t r;
        r = s;
        if (s.tnew != 2'd0) begin
            r.tnew = s.tnew - 2'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand hazard check: finds the nearest pending write to the operand register and
// decides between stalling and forwarding from that stage.
module hazard_match
    import pipe_pkg::*;
(
    input  logic [4:0] src,
    input  logic [1:0] tuse,
    input  shadow_t    e_ent,
    input  shadow_t    m_ent,
    input  shadow_t    w_ent,
    output logic       stall_op,
    output logic [1:0] sel
);

    logic     used;
    logic     hit;
    shadow_t  near;
    fwd_sel_t code;

    // Nearest match wins (E > M > W); its latency alone decides stall vs forward
    always_comb begin
        used     = (src != 5'd0) && (tuse != TUSE_NONE);
        hit      = 1'b0;
        near     = '0;
        code     = FWD_RF;
        stall_op = 1'b0;
        sel      = FWD_RF;
        if (used && (e_ent.dst == src)) begin
            hit  = 1'b1;
            near = e_ent;
            code = FWD_E;
        end else if (used && (m_ent.dst == src)) begin
            hit  = 1'b1;
            near = m_ent;
            code = FWD_M;
        end else if (used && (w_ent.dst == src)) begin
            hit  = 1'b1;
            near = w_ent;
            code = FWD_W;
        end
        if (hit) begin
            stall_op = near.tnew > tuse;
            // A not-yet-ready producer that needs no stall is picked up by a later-stage forward
            if (near.tnew == 2'd0) begin
                sel = code;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: shadow E/M/W write tracking, stall/forward decisions
// and the multiply/divide busy countdown.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_dst,
    input  logic [1:0] d_tnew,
    input  logic       d_md_start,
    input  logic       d_md_is_div,
    input  logic       d_md_use,
    input  logic       flush,
    output logic       stall,
    output logic [1:0] fwd_rs_sel,
    output logic [1:0] fwd_rt_sel,
    output logic       md_busy
);

    localparam int unsigned CNT_W = $clog2(DIV_CYCLES + 1);

    shadow_t          e_q, m_q, w_q;
    shadow_t          e_d, m_d, w_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;
    logic             stall_rs, stall_rt, md_accept;

    hazard_match u_match_rs (
        .src      (d_rs),
        .tuse     (d_tuse_rs),
        .e_ent    (e_q),
        .m_ent    (m_q),
        .w_ent    (w_q),
        .stall_op (stall_rs),
        .sel      (fwd_rs_sel)
    );

    hazard_match u_match_rt (
        .src      (d_rt),
        .tuse     (d_tuse_rt),
        .e_ent    (e_q),
        .m_ent    (m_q),
        .w_ent    (w_q),
        .stall_op (stall_rt),
        .sel      (fwd_rt_sel)
    );

    assign md_busy = cnt_q != '0;
    assign stall   = stall_rs | stall_rt | (d_md_use & md_busy);

    // Shadow pipeline advance: flush clears, stall injects a bubble into E
    always_comb begin
        e_d = '0;
        m_d = '0;
        w_d = '0;
        if (!flush) begin
            m_d = age(e_q);
            w_d = age(m_q);
            if (!stall) begin
                e_d = '{dst: d_dst, tnew: d_tnew, md: d_md_start};
            end
        end
    end

    // MDU countdown: load on accepted start; a flush kills it only while the op is still in E
    always_comb begin
        md_accept = d_md_start & ~stall & ~flush;
        cnt_dec   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
        cnt_d     = cnt_dec;
        if (flush) begin
            if (e_q.md) begin
                cnt_d = '0;
            end
        end else if (md_accept) begin
            cnt_d = d_md_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= '0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares them against {stall, fwd_rs_sel, fwd_rt_sel, md_busy}.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] d_rs = '0, d_rt = '0, d_dst = '0;
    logic [1:0] d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, d_tnew = '0;
    logic       d_md_start = 1'b0, d_md_is_div = 1'b0, d_md_use = 1'b0, flush = 1'b0;
    logic       stall, md_busy;
    logic [1:0] fwd_rs_sel, fwd_rt_sel;

    int tests  = 0;
    int failed = 0;

    logic [5:0] exp_q[$];
    string      name_q[$];

    hazard_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_tuse_rs   (d_tuse_rs),
        .d_tuse_rt   (d_tuse_rt),
        .d_dst       (d_dst),
        .d_tnew      (d_tnew),
        .d_md_start  (d_md_start),
        .d_md_is_div (d_md_is_div),
        .d_md_use    (d_md_use),
        .flush       (flush),
        .stall       (stall),
        .fwd_rs_sel  (fwd_rs_sel),
        .fwd_rt_sel  (fwd_rt_sel),
        .md_busy     (md_busy)
    );

    always #5 clk = ~clk;

    // Apply one cycle of D-stage inputs just after the rising edge
    task automatic step(input logic rst, input logic [4:0] rs, input logic [1:0] tus,
                        input logic [4:0] rt, input logic [1:0] tut, input logic [4:0] dst,
                        input logic [1:0] tnew, input logic mds, input logic mdd,
                        input logic mdu, input logic fl);
        @(posedge clk);
        #1;
        reset       = rst;
        d_rs        = rs;
        d_tuse_rs   = tus;
        d_rt        = rt;
        d_tuse_rt   = tut;
        d_dst       = dst;
        d_tnew      = tnew;
        d_md_start  = mds;
        d_md_is_div = mdd;
        d_md_use    = mdu;
        flush       = fl;
    endtask

    task automatic idle(input logic rst, input logic fl);
        step(rst, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, fl);
    endtask

    // Expected outputs for the cycle just driven
    task automatic chk(input string nm, input logic st, input logic [1:0] rs_sel,
                       input logic [1:0] rt_sel, input logic busy);
        exp_q.push_back({st, rs_sel, rt_sel, busy});
        name_q.push_back(nm);
    endtask

    // Monitor: compare mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [5:0] e, a;
            string      n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {stall, fwd_rs_sel, fwd_rt_sel, md_busy};
            tests++;
            if (a !== e) begin
                failed++;
                $display("FAIL %s: got stall=%b rs=%0d rt=%0d busy=%b, want stall=%b rs=%0d rt=%0d busy=%b",
                         n, a[5], a[4:3], a[2:1], a[0], e[5], e[4:3], e[2:1], e[0]);
            end
        end
    end

    initial begin
        // Reset state
        idle(1'b1, 1'b0);                                         chk("reset", 0, 0, 0, 0);

        // jal then jr $31: ready in E, forward from E
        step(0, 0, 3, 0, 3, 31, 0, 0, 0, 0, 0);                   chk("jal_issue", 0, 0, 0, 0);
        step(0, 31, 0, 0, 3, 0, 0, 0, 0, 0, 0);                   chk("jr_fwd_e", 0, 1, 0, 0);

        // lw $1 then beq $1,$1: E tnew2, M tnew1 stall; W tnew0 forwards from W
        step(0, 0, 3, 0, 3, 1, 2, 0, 0, 0, 0);                    chk("lw1_issue", 0, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);                    chk("beq_stall_e", 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);                    chk("beq_stall_m", 1, 0, 0, 0);
        step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);                    chk("beq_fwd_w", 0, 3, 3, 0);

        // lw $3, addu $3, add $3 (tuse 1): nearest is E tnew1 -> no stall, RF select
        step(0, 0, 3, 0, 3, 3, 2, 0, 0, 0, 0);                    chk("lw3_issue", 0, 0, 0, 0);
        step(0, 0, 3, 0, 3, 3, 1, 0, 0, 0, 0);                    chk("addu3_issue", 0, 0, 0, 0);
        step(0, 3, 1, 3, 3, 4, 1, 0, 0, 0, 0);                    chk("add_near_e", 0, 0, 0, 0);
        // Next cycle addu in M (tnew0) shadows lw in W; rt unused -> RF
        step(0, 3, 1, 3, 3, 0, 1, 0, 0, 0, 0);                    chk("add_fwd_m", 0, 2, 0, 0);

        // rt-only hazard with tuse 1
        step(0, 0, 3, 0, 3, 6, 2, 0, 0, 0, 0);                    chk("lw6_issue", 0, 0, 0, 0);
        step(0, 0, 3, 6, 1, 0, 0, 0, 0, 0, 0);                    chk("rt_stall_e", 1, 0, 0, 0);
        step(0, 0, 3, 6, 1, 0, 0, 0, 0, 0, 0);                    chk("rt_ok_m", 0, 0, 0, 0);

        // lw $5 flushed out of E
        step(0, 0, 3, 0, 3, 5, 2, 0, 0, 0, 0);                    chk("lw5_issue", 0, 0, 0, 0);
        step(0, 5, 0, 0, 3, 0, 0, 0, 0, 0, 1);                    chk("flush_cycle", 1, 0, 0, 0);
        step(0, 5, 0, 0, 3, 0, 0, 0, 0, 0, 0);                    chk("after_flush", 0, 0, 0, 0);
        idle(1'b0, 1'b0);

        // div accepted, mflo held for 10 cycles then issues
        step(0, 0, 3, 0, 3, 0, 0, 1, 1, 1, 0);                    chk("div_issue", 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 3, 0, 3, 7, 2, 0, 0, 1, 0);                chk("mflo_held", 1, 0, 0, 1);
        end
        step(0, 0, 3, 0, 3, 7, 2, 0, 0, 1, 0);                    chk("mflo_go", 0, 0, 0, 0);

        // mult countdown interrupted by reset at counter 3
        step(0, 0, 3, 0, 3, 0, 0, 1, 0, 1, 0);                    chk("mult_issue", 0, 0, 0, 0);
        step(0, 0, 3, 0, 3, 8, 2, 0, 0, 0, 0);                    chk("lw8_busy", 0, 0, 0, 1);
        step(0, 0, 3, 0, 3, 9, 1, 0, 0, 0, 0);                    chk("addu9_busy", 0, 0, 0, 1);
        step(1, 8, 0, 0, 3, 10, 2, 0, 0, 1, 0);                   chk("pre_reset", 1, 0, 0, 1);
        step(0, 8, 0, 0, 3, 10, 2, 0, 0, 1, 0);                   chk("post_reset", 0, 0, 0, 0);

        // Flush while the mult is still in E kills the countdown
        step(0, 0, 3, 0, 3, 0, 0, 1, 0, 1, 0);                    chk("mult2_issue", 0, 0, 0, 0);
        idle(1'b0, 1'b1);                                         chk("flush_md", 0, 0, 0, 1);
        idle(1'b0, 1'b0);                                         chk("flush_md_clear", 0, 0, 0, 0);

        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        if (exp_q.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
